// File: rtl/gpr_wbu_pkg.sv
// Shared constants and types for the write-back unit and its register file.
package gpr_wbu_pkg;

    localparam int unsigned GPR_DATAWIDTH = 32;
    localparam int unsigned GPR_NR        = 32;
    localparam int unsigned GPR_ADDRW     = $clog2(GPR_NR);

    // ABI register indices
    localparam logic [GPR_ADDRW-1:0] GPR_ZERO = 5'd0;
    localparam logic [GPR_ADDRW-1:0] GPR_SP   = 5'd2;
    localparam logic [GPR_ADDRW-1:0] GPR_A0   = 5'd10;

    // Pending-buffer occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_PEND  = 1'b1
    } wbu_state_e;

    // One buffered EXU result awaiting commit
    typedef struct packed {
        logic                     wen;
        logic [GPR_ADDRW-1:0]     rd;
        logic [GPR_DATAWIDTH-1:0] data;
    } wbu_pend_t;

endpackage

// File: rtl/gpr_wbu_regfile.sv
// General-purpose register array: one synchronous write port, two
// combinational read ports, asynchronous clear. Writes to x0 are dropped,
// so x0 always reads zero.
module gpr_regfile
    import gpr_wbu_pkg::*;
#(
    parameter int unsigned DATAWIDTH = GPR_DATAWIDTH,
    parameter int unsigned NR_REGS   = GPR_NR,
    parameter int unsigned ADDRW     = $clog2(NR_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_we,
    input  logic [ADDRW-1:0]     i_waddr,
    input  logic [DATAWIDTH-1:0] i_wdata,
    input  logic [ADDRW-1:0]     i_raddr1,
    input  logic [ADDRW-1:0]     i_raddr2,
    output logic [DATAWIDTH-1:0] o_rdata1,
    output logic [DATAWIDTH-1:0] o_rdata2
);

    logic [DATAWIDTH-1:0] r_mem [NR_REGS];
    logic                 w_we_eff;

    // Suppress writes that target x0
    always_comb begin
        w_we_eff = i_we && (i_waddr != '0);
    end

    // Register array: cleared on reset, written on the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NR_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we_eff) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read ports
    always_comb begin
        o_rdata1 = r_mem[i_raddr1];
        o_rdata2 = r_mem[i_raddr2];
    end

endmodule

// File: rtl/gpr_wbu.sv
// Write-back unit: accepts EXU results over valid/ready, buffers one entry,
// commits it to the GPR file, forwards the pending value to the read ports
// and counts retired instructions.
module gpr_wbu
    import gpr_wbu_pkg::*;
#(
    parameter int unsigned DATAWIDTH   = GPR_DATAWIDTH,
    parameter int unsigned NR_REGS     = GPR_NR,
    parameter int unsigned ADDRW       = $clog2(NR_REGS),
    parameter logic [31:0] RETIRE_INIT = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 exu_valid,
    output logic                 exu_ready,
    input  logic                 exu_wen,
    input  logic [ADDRW-1:0]     exu_rd,
    input  logic [DATAWIDTH-1:0] exu_data,
    input  logic                 wb_stall,
    input  logic [ADDRW-1:0]     raddr1,
    input  logic [ADDRW-1:0]     raddr2,
    output logic [DATAWIDTH-1:0] rdata1,
    output logic [DATAWIDTH-1:0] rdata2,
    output logic                 wb_done,
    output logic [31:0]          retire_cnt
);

    wbu_state_e           r_state;
    wbu_state_e           w_state_nxt;

    logic                 r_pend_wen;
    logic [ADDRW-1:0]     r_pend_rd;
    logic [DATAWIDTH-1:0] r_pend_data;

    logic                 r_wb_done;
    logic [31:0]          r_retire_cnt;

    logic                 w_pend_valid;
    logic                 w_accept;
    logic                 w_commit;
    logic                 w_ready;
    logic                 w_fwd1;
    logic                 w_fwd2;
    logic [DATAWIDTH-1:0] w_rf_rdata1;
    logic [DATAWIDTH-1:0] w_rf_rdata2;

    // State register: pending buffer occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: an accept always leaves an entry pending; a lone commit empties it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_PEND;
            ST_PEND:  if (w_commit && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake and commit decode: a stalled full buffer refuses new results
    always_comb begin
        w_pend_valid = (r_state == ST_PEND);
        w_ready      = !w_pend_valid || !wb_stall;
        w_accept     = exu_valid && w_ready;
        w_commit     = w_pend_valid && !wb_stall;
    end

    // Pending entry payload, loaded only on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_wen  <= 1'b0;
            r_pend_rd   <= '0;
            r_pend_data <= '0;
        end else if (w_accept) begin
            r_pend_wen  <= exu_wen;
            r_pend_rd   <= exu_rd;
            r_pend_data <= exu_data;
        end
    end

    // Retire pulse and wrapping retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_done    <= 1'b0;
            r_retire_cnt <= RETIRE_INIT;
        end else begin
            r_wb_done <= w_commit;
            if (w_commit) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    gpr_regfile #(
        .DATAWIDTH (DATAWIDTH),
        .NR_REGS   (NR_REGS),
        .ADDRW     (ADDRW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_commit && r_pend_wen),
        .i_waddr  (r_pend_rd),
        .i_wdata  (r_pend_data),
        .i_raddr1 (raddr1),
        .i_raddr2 (raddr2),
        .o_rdata1 (w_rf_rdata1),
        .o_rdata2 (w_rf_rdata2)
    );

    // Read ports: x0 is zero, otherwise the pending write wins over the array
    always_comb begin
        w_fwd1 = w_pend_valid && r_pend_wen && (r_pend_rd == raddr1);
        w_fwd2 = w_pend_valid && r_pend_wen && (r_pend_rd == raddr2);

        if (raddr1 == '0)  rdata1 = '0;
        else if (w_fwd1)   rdata1 = r_pend_data;
        else               rdata1 = w_rf_rdata1;

        if (raddr2 == '0)  rdata2 = '0;
        else if (w_fwd2)   rdata2 = r_pend_data;
        else               rdata2 = w_rf_rdata2;
    end

    // Output drive
    always_comb begin
        exu_ready  = w_ready;
        wb_done    = r_wb_done;
        retire_cnt = r_retire_cnt;
    end

endmodule

// File: tb/tb_gpr_wbu.sv
// Directed self-checking bench for gpr_wbu.
module tb_gpr_wbu;

    logic        clk;
    logic        rst_n;
    logic        exu_valid;
    logic        exu_ready;
    logic        exu_wen;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        wb_stall;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        wb_done;
    logic [31:0] retire_cnt;

    // Second instance with the counter preset near wrap
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_rdata1;
    logic [31:0] w_rdata2;
    logic        w_done;
    logic [31:0] w_cnt;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned pulses;

    gpr_wbu u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .exu_valid  (exu_valid),
        .exu_ready  (exu_ready),
        .exu_wen    (exu_wen),
        .exu_rd     (exu_rd),
        .exu_data   (exu_data),
        .wb_stall   (wb_stall),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .wb_done    (wb_done),
        .retire_cnt (retire_cnt)
    );

    gpr_wbu #(.RETIRE_INIT(32'hFFFF_FFFF)) u_dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .exu_valid  (w_valid),
        .exu_ready  (w_ready),
        .exu_wen    (1'b0),
        .exu_rd     (5'd0),
        .exu_data   (32'h0),
        .wb_stall   (1'b0),
        .raddr1     (5'd0),
        .raddr2     (5'd0),
        .rdata1     (w_rdata1),
        .rdata2     (w_rdata2),
        .wb_done    (w_done),
        .retire_cnt (w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wen, input logic [4:0] rd, input logic [31:0] d);
        exu_valid = v;
        exu_wen   = wen;
        exu_rd    = rd;
        exu_data  = d;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; pulses = 0;
        rst_n = 1'b0; wb_stall = 1'b0; raddr1 = '0; raddr2 = '0; w_valid = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_ready", {31'd0, exu_ready}, 32'd1);
        check("rst_cnt", retire_cnt, 32'd0);
        check("rst_done", {31'd0, wb_done}, 32'd0);

        // Write/read with forwarding
        tick();
        drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF); raddr1 = 5'd5;
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0); #1;
        check("wr_fwd", rdata1, 32'hDEAD_BEEF);
        check("wr_nodone", {31'd0, wb_done}, 32'd0);
        tick();
        check("wr_gpr", rdata1, 32'hDEAD_BEEF);
        check("wr_done", {31'd0, wb_done}, 32'd1);
        check("wr_cnt", retire_cnt, 32'd1);

        // x0 write discarded but retired
        drive(1'b1, 1'b1, 5'd0, 32'h0000_1234); raddr1 = 5'd0;
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0); #1;
        check("x0_pend_rd", rdata1, 32'd0);
        tick();
        check("x0_rd", rdata1, 32'd0);
        check("x0_done", {31'd0, wb_done}, 32'd1);
        check("x0_cnt", retire_cnt, 32'd2);

        // Back-to-back: one result per cycle
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b1, 5'(k), 32'(k * 3)); #1;
            check($sformatf("b2b_ready%0d", k), {31'd0, exu_ready}, 32'd1);
            tick();
            if (wb_done) pulses++;
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            if (wb_done) pulses++;
        end
        check("b2b_pulses", pulses, 32'd8);
        check("b2b_cnt", retire_cnt, 32'd10);
        for (int k = 1; k <= 8; k++) begin
            raddr1 = 5'(k); raddr2 = 5'(9 - k); #1;
            check($sformatf("b2b_r1_%0d", k), rdata1, 32'(k * 3));
            check($sformatf("b2b_r2_%0d", k), rdata2, 32'((9 - k) * 3));
        end

        // Stall holds the pending entry, forwarding stays active
        tick();
        drive(1'b1, 1'b1, 5'd7, 32'd9);
        tick();
        wb_stall = 1'b1; raddr2 = 5'd7;
        drive(1'b1, 1'b1, 5'd7, 32'd99); #1;
        check("stl_ready", {31'd0, exu_ready}, 32'd0);
        check("stl_fwd", rdata2, 32'd9);
        tick();
        check("stl_nodone", {31'd0, wb_done}, 32'd0);
        tick();
        check("stl_nodone2", {31'd0, wb_done}, 32'd0);
        check("stl_hold", rdata2, 32'd9);
        check("stl_cnt", retire_cnt, 32'd10);
        wb_stall = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check("stl_done", {31'd0, wb_done}, 32'd1);
        check("stl_gpr", rdata2, 32'd9);
        check("stl_cnt2", retire_cnt, 32'd11);

        // wen=0 retire leaves the register untouched
        drive(1'b1, 1'b1, 5'd3, 32'd2);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 5'd3, 32'hFF); raddr1 = 5'd3;
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0); #1;
        check("nw_pend", rdata1, 32'd2);
        tick();
        check("nw_done", {31'd0, wb_done}, 32'd1);
        check("nw_gpr", rdata1, 32'd2);
        check("nw_cnt", retire_cnt, 32'd13);

        // Counter wrap on the preset instance
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0; #1;
        check("wrap_pre", w_cnt, 32'hFFFF_FFFF);
        tick();
        check("wrap_done", {31'd0, w_done}, 32'd1);
        check("wrap_cnt", w_cnt, 32'd0);

        // Reset mid-operation with an entry pending
        drive(1'b1, 1'b1, 5'd4, 32'd55);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        raddr1 = 5'd4; #1;
        check("mrst_pend", rdata1, 32'd55);
        rst_n = 1'b0; #1;
        check("mrst_cnt", retire_cnt, 32'd0);
        check("mrst_done", {31'd0, wb_done}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a); #1;
            check($sformatf("mrst_r1_%0d", a), rdata1, 32'd0);
            check($sformatf("mrst_r2_%0d", a), rdata2, 32'd0);
        end
        tick();
        rst_n = 1'b1; raddr1 = 5'd4; #1;
        check("mrst_ready", {31'd0, exu_ready}, 32'd1);
        tick();
        check("mrst_drop", rdata1, 32'd0);
        check("mrst_nodone", {31'd0, wb_done}, 32'd0);
        check("mrst_cnt2", retire_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
